muon_pulse_generator: RTL and testbench

//  Synthetic muon-decay stimulus source: emits a baseline-referenced pulse pair (entry pulse, then decay pulse

---
 rtl/muon_pkg.sv | 32 +++
 rtl/pulse_lfsr.sv | 32 +++
 rtl/muon_pulse_generator.sv | 204 ++++++++++++++++++++
 tb/tb_muon_pulse_generator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/muon_pkg.sv
// muon_pkg: shared constants, FSM state type and saturating arithmetic for the
// muon pulse generator.
//   DW / WIDTH_W / GAP_W / CNT_W : sample, pulse-width, gap/holdoff and pair-count widths
//   state_e                      : sequencer states
//   sat_add / sat_sub            : clamp to [0, 2^DW-1] instead of wrapping
//   LFSR_SEED / LFSR_TAPS        : x^16+x^14+x^13+x^11+1 Fibonacci LFSR, used only when
//                                  MUON_PULSE_RANDOM_GAP_EN is defined
package muon_pkg;

  localparam int DW      = 14;
  localparam int WIDTH_W = 8;
  localparam int GAP_W   = 16;
  localparam int CNT_W   = 32;
  localparam int LFSR_W  = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Tap bits 15,13,12,10 implement x^16+x^14+x^13+x^11+1.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {IDLE, P1, GAP, P2, HOLD} state_e;

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? {DW{1'b1}} : s[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b > a) ? {DW{1'b0}} : a - b;
  endfunction

endpackage

// File: rtl/pulse_lfsr.sv
// pulse_lfsr: 16-bit Fibonacci LFSR used to randomise the entry-to-decay gap.
// Only instantiated when MUON_PULSE_RANDOM_GAP_EN is defined.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, loads seed_i
//   en_i   : advance one step per cycle when high
//   seed_i : reset value
//   lfsr_o : current register contents
module pulse_lfsr
  import muon_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= seed_i;
    else       lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/muon_pulse_generator.sv
// muon_pulse_generator: synthetic muon-decay stimulus. Emits an entry pulse and,
// optionally, a decay pulse after a programmable gap, on a baseline-referenced
// 14-bit sample bus that loops back into the threshold trigger.
//   adc_clk / adc_rst      : clock, synchronous active-high reset
//   start                  : one-cycle request, ignored while busy
//   cont                   : re-arm after holdoff (sampled live at holdoff end)
//   double_en, pulse_edge  : pair vs single pulse, below vs above baseline
//   baseline, amplitude    : idle level and pulse height
//   width, gap, holdoff    : phase lengths in cycles (width/gap 0 act as 1)
//   gap_mask               : only with MUON_PULSE_RANDOM_GAP_EN, LFSR bits added to gap
//   dac_dat, pulse_act     : registered sample stream and pulse-level flag
//   busy, done, pair_count : not idle, end-of-sequence strobe, completed sequences
//
// state | meaning
// IDLE  | waiting for start, output follows live baseline
// P1    | entry pulse, width cycles
// GAP   | latched baseline between pulses, gap cycles
// P2    | decay pulse, width cycles
// HOLD  | latched baseline, holdoff cycles, then done and IDLE/re-arm
module muon_pulse_generator
  import muon_pkg::*;
(
  input  logic               adc_clk,
  input  logic               adc_rst,
  input  logic               start,
  input  logic               cont,
  input  logic               double_en,
  input  logic               pulse_edge,
  input  logic [DW-1:0]      baseline,
  input  logic [DW-1:0]      amplitude,
  input  logic [WIDTH_W-1:0] width,
  input  logic [GAP_W-1:0]   gap,
  input  logic [GAP_W-1:0]   holdoff,
`ifdef MUON_PULSE_RANDOM_GAP_EN
  input  logic [GAP_W-1:0]   gap_mask,
`endif
  output logic [DW-1:0]      dac_dat,
  output logic               pulse_act,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   pair_count
);

  localparam int WPAD = GAP_W - WIDTH_W;

  state_e               state_q, state_d;
  logic [GAP_W-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]        base_q, base_d, level_q, level_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [GAP_W-1:0]     gap_q, gap_d, hold_q, hold_d;
  logic                 dbl_q, dbl_d;
  logic [DW-1:0]        dac_q, dac_d;
  logic                 act_q, act_d, done_q, done_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 latch;
  logic                 last;
  logic [GAP_W-1:0]     gap_eff;

  // Phase ends when the loaded count is 0 or 1, so 0 and 1 give one cycle.
  assign last = ~|cnt_q[GAP_W-1:1];

`ifdef MUON_PULSE_RANDOM_GAP_EN
  logic [GAP_W-1:0] mask_q, mask_d, lfsr;
  logic [GAP_W:0]   gap_sum;

  pulse_lfsr u_lfsr (
    .clk_i  (adc_clk),
    .rst_i  (adc_rst),
    .en_i   (1'b1),
    .seed_i (LFSR_SEED),
    .lfsr_o (lfsr)
  );

  assign mask_d  = latch ? gap_mask : mask_q;
  assign gap_sum = {1'b0, gap_q} + {1'b0, lfsr & mask_q};
  assign gap_eff = gap_sum[GAP_W] ? {GAP_W{1'b1}} : gap_sum[GAP_W-1:0];

  always_ff @(posedge adc_clk) begin
    if (adc_rst) mask_q <= '0;
    else         mask_q <= mask_d;
  end
`else
  assign gap_eff = gap_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    count_d = count_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch   = 1'b1;
          state_d = P1;
          cnt_d   = {{WPAD{1'b0}}, width};
        end
      end
      P1: begin
        if (!last)         cnt_d = cnt_q - GAP_W'(1);
        else if (dbl_q) begin
          state_d = GAP;
          cnt_d   = gap_eff;
        end else begin
          state_d = HOLD;
          cnt_d   = hold_q;
        end
      end
      GAP: begin
        if (!last) cnt_d = cnt_q - GAP_W'(1);
        else begin
          state_d = P2;
          cnt_d   = {{WPAD{1'b0}}, width_q};
        end
      end
      P2: begin
        if (!last) cnt_d = cnt_q - GAP_W'(1);
        else begin
          state_d = HOLD;
          cnt_d   = hold_q;
        end
      end
      HOLD: begin
        if (!last) cnt_d = cnt_q - GAP_W'(1);
        else begin
          done_d  = 1'b1;
          count_d = count_q + CNT_W'(1);
          if (cont) begin
            latch   = 1'b1;
            state_d = P1;
            cnt_d   = {{WPAD{1'b0}}, width};
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    base_d  = base_q;
    level_d = level_q;
    width_d = width_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    dbl_d   = dbl_q;
    if (latch) begin
      base_d  = baseline;
      level_d = pulse_edge ? sat_sub(baseline, amplitude) : sat_add(baseline, amplitude);
      width_d = width;
      gap_d   = gap;
      hold_d  = holdoff;
      dbl_d   = double_en;
    end

    dac_d = base_q;
    act_d = 1'b0;
    case (state_q)
      IDLE:    dac_d = baseline;
      P1, P2: begin
        dac_d = level_q;
        act_d = 1'b1;
      end
      default: dac_d = base_q;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (adc_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      level_q <= '0;
      width_q <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      dbl_q   <= 1'b0;
      dac_q   <= '0;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      level_q <= level_d;
      width_q <= width_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      dbl_q   <= dbl_d;
      dac_q   <= dac_d;
      act_q   <= act_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  assign dac_dat    = dac_q;
  assign pulse_act  = act_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign pair_count = count_q;

endmodule

// File: tb/tb_muon_pulse_generator.sv
// Self-checking bench for muon_pulse_generator. Expected streams come from a
// phase-list model: a sequence is W pulse samples, then (pair only) G baseline
// and W pulse samples, then H baseline samples, all shifted by the output register.
module tb_muon_pulse_generator;

  logic        adc_clk = 1'b0;
  logic        adc_rst;
  logic        start, cont, double_en, pulse_edge;
  logic [13:0] baseline, amplitude;
  logic [7:0]  width;
  logic [15:0] gap, holdoff;
`ifdef MUON_PULSE_RANDOM_GAP_EN
  logic [15:0] gap_mask = 16'h0000;
`endif
  logic [13:0] dac_dat;
  logic        pulse_act, busy, done;
  logic [31:0] pair_count;

  int vectors   = 0;
  int errors    = 0;
  int exp_count = 0;

  always #5 adc_clk = ~adc_clk;

  muon_pulse_generator dut (
    .adc_clk    (adc_clk),
    .adc_rst    (adc_rst),
    .start      (start),
    .cont       (cont),
    .double_en  (double_en),
    .pulse_edge (pulse_edge),
    .baseline   (baseline),
    .amplitude  (amplitude),
    .width      (width),
    .gap        (gap),
    .holdoff    (holdoff),
`ifdef MUON_PULSE_RANDOM_GAP_EN
    .gap_mask   (gap_mask),
`endif
    .dac_dat    (dac_dat),
    .pulse_act  (pulse_act),
    .busy       (busy),
    .done       (done),
    .pair_count (pair_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int b, input int a, input bit e, input int w, input int g,
                         input int h, input bit d);
    baseline   = 14'(b);
    amplitude  = 14'(a);
    pulse_edge = e;
    width      = 8'(w);
    gap        = 16'(g);
    holdoff    = 16'(h);
    double_en  = d;
  endtask

  // Called #1 after an edge: request a sequence, the next edge accepts it.
  task automatic kick();
    start = 1'b1;
    @(posedge adc_clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Checks one whole sequence from the current config inputs (latched at the
  // start edge just passed). rearm=1 means cont is high at holdoff end.
  task automatic run_seq(input bit scramble, input bit rearm);
    int w, g, h, L, lvl, base, j;
    bit dbl, p;
    w    = (width == 0)   ? 1 : int'(width);
    g    = (gap == 0)     ? 1 : int'(gap);
    h    = (holdoff == 0) ? 1 : int'(holdoff);
    dbl  = double_en;
    base = int'(baseline);
    lvl  = pulse_edge ? base - int'(amplitude) : base + int'(amplitude);
    if (lvl < 0)     lvl = 0;
    if (lvl > 16383) lvl = 16383;
    L = w + (dbl ? g + w : 0) + h;
    for (int k = 1; k <= L; k++) begin
      @(posedge adc_clk); #1;
      j = k - 1;
      p = (j < w) || (dbl && j >= w + g && j < 2 * w + g);
      if (k == L) exp_count++;
      chk("dac_dat", {18'd0, dac_dat}, p ? lvl : base);
      chk("pulse_act", {31'd0, pulse_act}, {31'd0, p});
      chk("busy", {31'd0, busy}, {31'd0, (k < L) || rearm});
      chk("done", {31'd0, done}, {31'd0, k == L});
      chk("pair_count", pair_count, exp_count);
      if (scramble && k < L) begin
        start      = 1'b1;
        baseline   = 14'($urandom_range(0, 16383));
        amplitude  = 14'($urandom_range(0, 16383));
        width      = 8'($urandom_range(0, 255));
        gap        = 16'($urandom_range(0, 65535));
        holdoff    = 16'($urandom_range(0, 65535));
        double_en  = 1'($urandom_range(0, 1));
        pulse_edge = 1'($urandom_range(0, 1));
      end
      if (k == L) start = 1'b0;
    end
    if (!rearm) begin
      @(posedge adc_clk); #1;
      chk("idle_dac_live_baseline", {18'd0, dac_dat}, {18'd0, baseline});
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_pulse_act", {31'd0, pulse_act}, 32'd0);
    end
  endtask

  initial begin
    adc_rst = 1'b1;
    start   = 1'b0;
    cont    = 1'b0;
    set_cfg(123, 0, 1'b0, 1, 1, 0, 1'b0);
    repeat (3) @(posedge adc_clk);
    #1;
    chk("rst_dac", {18'd0, dac_dat}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pulse_act", {31'd0, pulse_act}, 32'd0);
    chk("rst_count", pair_count, 32'd0);
    adc_rst = 1'b0;

    // Reference pair: 4 @10000, 10 @8000, 4 @10000.
    set_cfg(8000, 2000, 1'b0, 4, 10, 0, 1'b1);
    kick();
    run_seq(1'b0, 1'b0);

    // Saturation at both rails.
    set_cfg(100, 500, 1'b1, 3, 2, 1, 1'b1);
    kick();
    run_seq(1'b0, 1'b0);
    set_cfg(16000, 1000, 1'b0, 2, 1, 2, 1'b0);
    kick();
    run_seq(1'b0, 1'b0);

    // Zero lengths behave as one.
    set_cfg(4000, 50, 1'b0, 0, 0, 0, 1'b1);
    kick();
    run_seq(1'b0, 1'b0);

    // Start spam and config churn mid-run.
    set_cfg(9000, 700, 1'b1, 5, 6, 3, 1'b1);
    kick();
    run_seq(1'b1, 1'b0);

    // Free-running, then drop cont.
    set_cfg(5000, 300, 1'b0, 2, 3, 20, 1'b1);
    cont = 1'b1;
    kick();
    run_seq(1'b0, 1'b1);
    run_seq(1'b0, 1'b1);
    cont = 1'b0;
    run_seq(1'b0, 1'b0);

    // Random sequences.
    for (int n = 0; n < 14; n++) begin
      set_cfg($urandom_range(0, 16383), $urandom_range(0, 16383), 1'($urandom_range(0, 1)),
              $urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 8),
              1'($urandom_range(0, 1)));
      kick();
      run_seq(1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset during GAP aborts the sequence.
    set_cfg(8000, 2000, 1'b0, 3, 10, 4, 1'b1);
    kick();
    repeat (5) @(posedge adc_clk);
    #1;
    chk("in_gap_busy", {31'd0, busy}, 32'd1);
    adc_rst = 1'b1;
    @(posedge adc_clk); #1;
    exp_count = 0;
    chk("abort_dac", {18'd0, dac_dat}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_count", pair_count, exp_count);
    chk("abort_pulse_act", {31'd0, pulse_act}, 32'd0);

    // Reset wins over a simultaneous start.
    start = 1'b1;
    @(posedge adc_clk); #1;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    start   = 1'b0;
    adc_rst = 1'b0;

    // Reference pair again after reset.
    set_cfg(8000, 2000, 1'b0, 4, 10, 0, 1'b1);
    kick();
    run_seq(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
